// File: rtl/aec_pkg.sv
// Shared definitions for the ASCII expression calculator: character codes,
// FSM states, token types and the character classifier.
package aec_pkg;

    localparam logic [7:0] CH_EQ  = 8'h3d;
    localparam logic [7:0] CH_LP  = 8'h28;
    localparam logic [7:0] CH_RP  = 8'h29;
    localparam logic [7:0] CH_ADD = 8'h2b;
    localparam logic [7:0] CH_SUB = 8'h2d;
    localparam logic [7:0] CH_MUL = 8'h2a;

    typedef enum logic [2:0] {IDLE, CAPTURE, CONVERT, DRAIN, EVAL, DONE} state_t;
    typedef enum logic [2:0] {NUM, ADD, SUB, MUL, LPAR, RPAR} tok_t;

    typedef struct packed {
        logic       legal;
        logic       digit;
        logic       eq;
        tok_t       typ;
        logic [3:0] val;
    } ch_info_t;

    function automatic ch_info_t decode_char(input logic [7:0] c);
        ch_info_t info;
        info.legal = 1'b1;
        info.digit = 1'b0;
        info.eq    = 1'b0;
        info.typ   = NUM;
        info.val   = 4'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            info.digit = 1'b1;
            info.val   = 4'(c - 8'h30);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            info.digit = 1'b1;
            info.val   = 4'(c - 8'h57);
        end else begin
            case (c)
                CH_ADD:  info.typ = ADD;
                CH_SUB:  info.typ = SUB;
                CH_MUL:  info.typ = MUL;
                CH_LP:   info.typ = LPAR;
                CH_RP:   info.typ = RPAR;
                CH_EQ:   info.eq  = 1'b1;
                default: info.legal = 1'b0;
            endcase
        end
        return info;
    endfunction

    function automatic logic [1:0] prec_of(input tok_t t);
        case (t)
            MUL:     prec_of = 2'd2;
            ADD,
            SUB:     prec_of = 2'd1;
            default: prec_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/aec_stack.sv
// LIFO with registered storage; push and pop together replace the top entry.
module aec_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [AW-1:0]    top_idx;

    assign top_idx = AW'(sp - 1'b1);
    assign top     = mem[top_idx];
    assign full    = (sp == CW'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && pop) begin
            if (!empty) mem[top_idx] <= din;
        end else if (push) begin
            if (!full) begin
                mem[AW'(sp)] <= din;
                sp           <= sp + 1'b1;
            end
        end else if (pop) begin
            if (!empty) sp <= sp - 1'b1;
        end
    end
endmodule

// File: rtl/aec_gen2.sv
// ASCII infix calculator: captures hex/operator characters, converts to postfix
// with a shunting-yard pass, then evaluates the postfix list on an operand stack.
module aec_gen2
    import aec_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_TOK   = 32,
    parameter int STK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic [7:0]        ascii_in,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic              error,
    output state_t            dbg_state
);
    // Handshake: ready is sampled only in IDLE and qualifies the first character;
    // valid is a one-cycle pulse in DONE, and result/error hold until the next pulse.
    localparam int TW = $clog2(MAX_TOK + 1);
    localparam int TI = $clog2(MAX_TOK);

    state_t            state;
    logic              err, num_open, eval_phase;
    logic [TW-1:0]     tok_cnt, rd_idx, post_cnt, post_idx;
    tok_t              tok_type  [MAX_TOK];
    logic [DATA_W-1:0] tok_val   [MAX_TOK];
    tok_t              post_type [MAX_TOK];
    logic [DATA_W-1:0] post_val  [MAX_TOK];
    logic [DATA_W-1:0] opnd_b;

    logic              op_push, op_pop, op_full, op_empty;
    logic [2:0]        op_din, op_top_raw;
    tok_t              op_top;
    logic              nd_push, nd_pop, nd_full, nd_empty;
    logic [DATA_W-1:0] nd_din, nd_top;
    logic              stk_clr_n;

    ch_info_t          ch;
    logic              accept, base_open, base_err;
    logic [TW-1:0]     base_cnt;
    logic [TI-1:0]     last_idx;
    tok_t              cur_t, post_t;
    logic [DATA_W-1:0] cur_v, post_v;
    logic              conv_end, eval_end;
    logic              emit, advance, fault;
    tok_t              emit_t;
    logic [DATA_W-1:0] emit_v;

    function automatic logic [DATA_W-1:0] apply_op(input tok_t op, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        case (op)
            ADD:     apply_op = a + b;
            SUB:     apply_op = a - b;
            default: apply_op = a * b;
        endcase
    endfunction

    // Stacks are held clear while idle so every expression starts empty.
    assign stk_clr_n = rst && (state != IDLE);
    assign op_top    = tok_t'(op_top_raw);
    assign dbg_state = state;

    assign ch        = decode_char(ascii_in);
    assign accept    = (state == CAPTURE) || (state == IDLE && ready);
    assign base_cnt  = (state == IDLE) ? '0 : tok_cnt;
    assign base_open = (state == IDLE) ? 1'b0 : num_open;
    assign base_err  = (state == IDLE) ? 1'b0 : err;
    assign last_idx  = TI'(tok_cnt - 1'b1);

    assign cur_t    = tok_type[TI'(rd_idx)];
    assign cur_v    = tok_val[TI'(rd_idx)];
    assign post_t   = post_type[TI'(post_idx)];
    assign post_v   = post_val[TI'(post_idx)];
    assign conv_end = (rd_idx == tok_cnt);
    assign eval_end = (post_idx == post_cnt);

    always_comb begin
        op_push = 1'b0;
        op_pop  = 1'b0;
        op_din  = cur_t;
        nd_push = 1'b0;
        nd_pop  = 1'b0;
        nd_din  = post_v;
        emit    = 1'b0;
        emit_t  = op_top;
        emit_v  = '0;
        advance = 1'b0;
        fault   = 1'b0;
        case (state)
            CONVERT: if (!conv_end) begin
                case (cur_t)
                    NUM: begin
                        emit    = 1'b1;
                        emit_t  = NUM;
                        emit_v  = cur_v;
                        advance = 1'b1;
                    end
                    LPAR: if (op_full) fault = 1'b1;
                          else begin op_push = 1'b1; advance = 1'b1; end
                    RPAR: if (op_empty) fault = 1'b1;
                          else if (op_top == LPAR) begin op_pop = 1'b1; advance = 1'b1; end
                          else begin op_pop = 1'b1; emit = 1'b1; end
                    default:
                        if (!op_empty && op_top != LPAR && prec_of(op_top) >= prec_of(cur_t)) begin
                            op_pop = 1'b1;
                            emit   = 1'b1;
                        end else if (op_full) fault = 1'b1;
                        else begin op_push = 1'b1; advance = 1'b1; end
                endcase
            end
            DRAIN: if (!op_empty) begin
                if (op_top == LPAR) fault = 1'b1;
                else begin op_pop = 1'b1; emit = 1'b1; end
            end
            // Operators take two cycles: pop the right operand, then fold into the top.
            EVAL: if (!eval_end && post_t == NUM) begin
                if (nd_full) fault = 1'b1;
                else nd_push = 1'b1;
            end else if (!eval_phase) begin
                if (nd_empty) fault = 1'b1;
                else nd_pop = 1'b1;
            end else if (eval_end) begin
                fault = !nd_empty;
            end else if (nd_empty) begin
                fault = 1'b1;
            end else begin
                nd_push = 1'b1;
                nd_pop  = 1'b1;
                nd_din  = apply_op(post_t, nd_top, opnd_b);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            valid      <= 1'b0;
            result     <= '0;
            error      <= 1'b0;
            err        <= 1'b0;
            num_open   <= 1'b0;
            eval_phase <= 1'b0;
            tok_cnt    <= '0;
            rd_idx     <= '0;
            post_cnt   <= '0;
            post_idx   <= '0;
            opnd_b     <= '0;
            for (int i = 0; i < MAX_TOK; i++) begin
                tok_type[i]  <= NUM;
                tok_val[i]   <= '0;
                post_type[i] <= NUM;
                post_val[i]  <= '0;
            end
        end else begin
            valid <= 1'b0;
            if (accept) begin
                state    <= CAPTURE;
                err      <= base_err;
                tok_cnt  <= base_cnt;
                num_open <= 1'b0;
                if (ch.eq) begin
                    busy       <= 1'b1;
                    rd_idx     <= '0;
                    post_cnt   <= '0;
                    post_idx   <= '0;
                    eval_phase <= 1'b0;
                    if (base_err) begin
                        state  <= DONE;
                        valid  <= 1'b1;
                        error  <= 1'b1;
                        result <= '0;
                    end else begin
                        state <= CONVERT;
                    end
                end else if (!base_err) begin
                    if (!ch.legal) begin
                        err <= 1'b1;
                    end else if (ch.digit && base_open) begin
                        tok_val[last_idx] <= (tok_val[last_idx] << 4) | DATA_W'(ch.val);
                        num_open          <= 1'b1;
                    end else if (base_cnt == TW'(MAX_TOK)) begin
                        err <= 1'b1;
                    end else begin
                        tok_type[TI'(base_cnt)] <= ch.typ;
                        tok_val[TI'(base_cnt)]  <= DATA_W'(ch.val);
                        tok_cnt                 <= base_cnt + 1'b1;
                        num_open                <= ch.digit;
                    end
                end
            end else begin
                case (state)
                    CONVERT, DRAIN: begin
                        if (fault) begin
                            state  <= DONE;
                            valid  <= 1'b1;
                            error  <= 1'b1;
                            result <= '0;
                        end else if (state == CONVERT && conv_end) begin
                            state <= DRAIN;
                        end else if (state == DRAIN && op_empty) begin
                            state <= EVAL;
                        end else begin
                            if (emit) begin
                                post_type[TI'(post_cnt)] <= emit_t;
                                post_val[TI'(post_cnt)]  <= emit_v;
                                post_cnt                 <= post_cnt + 1'b1;
                            end
                            if (advance) begin
                                rd_idx <= rd_idx + 1'b1;
                                if (rd_idx + 1'b1 == tok_cnt) state <= DRAIN;
                            end
                        end
                    end
                    EVAL: begin
                        if (fault) begin
                            state  <= DONE;
                            valid  <= 1'b1;
                            error  <= 1'b1;
                            result <= '0;
                        end else if (!eval_end && post_t == NUM) begin
                            post_idx <= post_idx + 1'b1;
                        end else if (!eval_phase) begin
                            opnd_b     <= nd_top;
                            eval_phase <= 1'b1;
                        end else if (eval_end) begin
                            state  <= DONE;
                            valid  <= 1'b1;
                            error  <= 1'b0;
                            result <= opnd_b;
                        end else begin
                            eval_phase <= 1'b0;
                            post_idx   <= post_idx + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    aec_stack #(.WIDTH(3), .DEPTH(STK_DEPTH)) u_op_stk (
        .clk   (clk),
        .clr_n (stk_clr_n),
        .push  (op_push),
        .pop   (op_pop),
        .din   (op_din),
        .top   (op_top_raw),
        .full  (op_full),
        .empty (op_empty)
    );

    aec_stack #(.WIDTH(DATA_W), .DEPTH(STK_DEPTH)) u_nd_stk (
        .clk   (clk),
        .clr_n (stk_clr_n),
        .push  (nd_push),
        .pop   (nd_pop),
        .din   (nd_din),
        .top   (nd_top),
        .full  (nd_full),
        .empty (nd_empty)
    );
endmodule

// File: doc/aec_gen2.md
AEC_GEN2 -- requirements
Module: aec_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the operand and result width (range 4..32).
REQ-002 SHALL have parameter MAX_TOK, default 32, giving the maximum number of tokens buffered per expression.
REQ-003 SHALL have parameter STK_DEPTH, default 16, giving the depth of both the operator stack and the operand stack.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 ready  input  1  high in the cycle carrying the first character of an expression.
REQ-007 ascii_in  input  8  one ASCII character per cycle.
REQ-008 busy  output  1  high from acceptance of '=' until the cycle after valid.
REQ-009 valid  output  1  one-cycle pulse marking result/error valid.
REQ-010 result  output  DATA_W  expression value, modulo 2^DATA_W.
REQ-011 error  output  1  qualified by valid; 1 = expression rejected.

Function
REQ-012 Legal characters SHALL be '0'-'9', 'a'-'f' (hex digits), '+', '-', '*', '(', ')', and '=' as the terminator.
REQ-013 Capture SHALL start on ready=1 with busy=0; that cycle and every following cycle SHALL accept one character until '='.
REQ-014 Consecutive hex digits SHALL merge into one number token: value = value*16 + digit, truncated to DATA_W bits.
REQ-015 Precedence SHALL be '*' above '+'/'-'; all operators left-associative; parentheses override.
REQ-016 Arithmetic SHALL be two's-complement modulo 2^DATA_W; subtraction underflow wraps without error.
REQ-017 FSM states SHALL be IDLE, CAPTURE, CONVERT (infix to postfix), DRAIN (pop remaining operators), EVAL, DONE.
REQ-018 Transitions: IDLE->CAPTURE on ready; CAPTURE->CONVERT on '='; CONVERT->DRAIN when input tokens are exhausted; DRAIN->EVAL when the operator stack is empty; EVAL->DONE when the postfix list is exhausted; DONE->IDLE.
REQ-019 CONVERT and EVAL SHALL each process at most one token or stack action per cycle; valid SHALL assert no later than 3*N+4 cycles after '=' is accepted (N = token count).
REQ-020 valid SHALL be high only in DONE, for exactly one cycle; result and error SHALL hold their values until the next valid.
REQ-021 Characters presented while busy=1, or in IDLE without ready, SHALL be ignored.
REQ-022 '=' arriving as the first character (ready cycle) SHALL produce valid with error=1.
REQ-023 Error=1, result=0 SHALL be reported on any of: an illegal character, token count > MAX_TOK, operator or operand stack overflow, unmatched '(' or ')', operand underflow in EVAL, or final operand count != 1.
REQ-024 On detecting an error, the block SHALL abandon remaining work, skip directly to DONE once '=' has been seen, and discard characters until '='.
REQ-025 ready asserted in the same cycle as valid SHALL be ignored; a new expression starts no earlier than the cycle after valid.

Reset
REQ-026 With rst=0 at a clock edge: state=IDLE; valid=0, error=0, busy=0, result=0; all pointers, counters and stacks cleared.
REQ-027 Reset asserted mid-operation SHALL abort the expression with no valid pulse; capture SHALL restart only on a new ready.

Structure
REQ-028 Shared package aec_pkg SHALL hold the ASCII constants ('=', '(', ')', '+', '-', '*'), the FSM state enum, and the token-type enum (NUM, ADD, SUB, MUL, LPAR, RPAR).
REQ-029 The operator and operand stacks SHALL each be an instance of one sub-module aec_stack, parametrised in WIDTH and DEPTH, with push/pop, top, full, empty and synchronous active-low clear.

Verification (DATA_W=16)
REQ-030 "1+2*3=" -> valid, result=0x0007, error=0.
REQ-031 "(a+5)*3-f=" -> result=0x001E.
REQ-032 "ff*ff=" -> result=0xFE01; "1-2=" -> result=0xFFFF.
REQ-033 "(1+2=" and "3+=" -> each produces valid, error=1, result=0.
REQ-034 rst=0 for one cycle after "12+"; then ready with "4*4=" -> result=0x0010, exactly one valid pulse.
REQ-035 Expression of MAX_TOK+1 tokens -> error=1; characters driven while busy=1 leave the current result unaffected.
